// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit and its ALU.
// Holds the FSM state type, the ALUOp classes, the opcode constants and the
// 3-bit ALU control codes (also consumed by the ALU itself).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's ALUOp class plus the instruction funct fields
// to the 3-bit ALU control code.
//   aluop         in  ALUOp class (add / sub / funct)
//   funct3        in  instr[14:12]
//   op5           in  instr[5], distinguishes R-type from I-type
//   funct7b5      in  instr[30]
//   alu_control   out ALU operation code
//   illegal_funct out funct3 not supported (only meaningful for ALUOP_FUNCT)
module alu_dec
  import riscv_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alu_control,
  output logic        illegal_funct
);

  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; addi ignores it
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal_funct = 1'b1;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit (Moore FSM) driving the ALU operand muxes,
// ALU control code and the PC/IR/register-file/memory write gates.
//   clk, rst_n   clock (rising edge), async active-low reset
//   op, funct3, funct7b5  instruction fields from IR
//   zero         ALU result is zero (branch condition)
//   mem_ready    memory access completes this cycle
//   pc_write, ir_write, mem_write, reg_write  write enables
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src  datapath selects
//   alu_control  ALU operation code
//   illegal      one-cycle pulse on unsupported op/funct
module mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit HAS_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t state, state_n;
  aluop_t aluop;
  logic   mr;
  logic   pc_update, branch, ir_w, mem_w, reg_w, illegal_op, illegal_funct;

  assign mr = HAS_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    aluop      = ALUOP_ADD;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
        ir_w       = mr;
        pc_update  = mr;
        if (mr) state_n = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECR;
          OP_ITYPE:     state_n = S_EXECI;
          OP_BEQ:       state_n = S_BEQ;
          OP_JAL:       state_n = S_JAL;
          default: begin
            state_n    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_n   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mr) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (mr) state_n = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        aluop     = ALUOP_FUNCT;
        state_n   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_n = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        state_n   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_n   = S_ALUWB;
      end
      default: state_n = S_FETCH;
    endcase
  end

  alu_dec u_alu_dec (
    .aluop         (aluop),
    .funct3        (funct3),
    .op5           (op[5]),
    .funct7b5      (funct7b5),
    .alu_control   (alu_control),
    .illegal_funct (illegal_funct)
  );

  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  // Enables are qualified by rst_n so they drop the instant reset asserts,
  // independent of the state register's async clear.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_w;
  assign mem_write = rst_n & mem_w;
  assign reg_write = rst_n & reg_w;
  assign illegal   = rst_n & (illegal_op |
                     (((state == S_EXECR) || (state == S_EXECI)) & illegal_funct));

endmodule
